vec_argmax_sink: RTL and testbench

Streaming receiver for the output side of a fully-connected layer. It consumes one M-word signed vector per inference over a valid/ready slave port and returns the index and value of the largest element over a valid/ready master port. It is placed after the last layer so that class selection happens in hardware. No vector storage is needed: the compare is a running reduction.

---
 rtl/vec_argmax_sink_if.sv | 25 ++
 rtl/vec_argmax_sink.sv | 95 +++++++++
 tb/tb_vec_argmax_sink.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_argmax_sink_if.sv
// Valid/ready bundle for vec_argmax_sink: word stream in, (index, max) result out.
// The slave modport is the sink's view; the master modport is the surrounding environment's view.
interface vec_argmax_sink_if #(
  parameter int M    = 4,
  parameter int T    = 16,
  parameter int logM = $clog2(M)
);
  logic                 s_valid;
  logic                 s_ready;
  logic signed [T-1:0]  data_in;
  logic                 m_valid;
  logic                 m_ready;
  logic [logM-1:0]      out_idx;
  logic signed [T-1:0]  out_max;

  modport slave (
    input  s_valid, data_in, m_ready,
    output s_ready, m_valid, out_idx, out_max
  );

  modport master (
    output s_valid, data_in, m_ready,
    input  s_ready, m_valid, out_idx, out_max
  );
endinterface

// File: rtl/vec_argmax_sink.sv
// Streaming argmax over M-word signed vectors; one registered (index, max) result per vector.
// Define ARGMAX_SKID_EN to let the next vector stream in while a result is still pending.
module vec_argmax_sink #(
  parameter int M    = 4,
  parameter int T    = 16,
  parameter int logM = $clog2(M)
) (
  input  logic              clk,
  input  logic              reset,
  vec_argmax_sink_if.slave  bus
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [logM-1:0] CNT_LAST = logM'(M - 1);

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [logM-1:0]      cnt;
  logic signed [T-1:0]  best;
  logic [logM-1:0]      best_idx;
  logic signed [T-1:0]  res_max;
  logic [logM-1:0]      res_idx;

  logic                 last;
  logic                 accept;
  logic                 load;
  logic                 drain;
  logic signed [T-1:0]  cand;
  logic [logM-1:0]      cand_idx;

  assign last = (cnt == CNT_LAST);

`ifdef ARGMAX_SKID_EN
  // Only the word that would overwrite a pending, undrained result has to wait.
  assign bus.s_ready = !reset && (!last || (state == ACCUM) || bus.m_ready);
`else
  assign bus.s_ready = !reset && (state == ACCUM);
`endif

  assign accept = bus.s_valid && bus.s_ready;
  assign load   = accept && last;
  assign drain  = bus.m_valid && bus.m_ready;

  assign bus.m_valid = (state == FULL);
  assign bus.out_idx = res_idx;
  assign bus.out_max = res_max;

  // Running reduction: the first word seeds the compare; later words win only when strictly larger.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cand     = best;
    cand_idx = best_idx;
    if ((cnt == '0) || (bus.data_in > best)) begin
      cand     = bus.data_in;
      cand_idx = cnt;
    end
  end

  // A load on the same edge as a drain keeps the result register occupied.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (load) state_nxt = FULL;
      FULL:    if (load) state_nxt = FULL;
               else if (drain) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACCUM;
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
      res_max  <= '0;
      res_idx  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt      <= last ? '0 : cnt + logM'(1);
        best     <= cand;
        best_idx <= cand_idx;
      end
      if (load) begin
        res_max <= cand;
        res_idx <= cand_idx;
      end
    end
  end

endmodule

// File: tb/tb_vec_argmax_sink.sv
// Scoreboard bench for vec_argmax_sink: randomized and directed vectors against a queue-based argmax model.
module tb_vec_argmax_sink;

  localparam int M    = 4;
  localparam int T    = 16;
  localparam int LOGM = $clog2(M);

  typedef logic signed [T-1:0] word_t;
  typedef struct {
    logic [LOGM-1:0] idx;
    word_t           max;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vec_argmax_sink_if #(.M(M), .T(T), .logM(LOGM)) bus ();

  vec_argmax_sink #(.M(M), .T(T), .logM(LOGM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: find the largest value, then the lowest index holding it.
  function automatic res_t ref_argmax(input word_t v[$]);
    res_t r;
    int   hi = int'(v[0]);
    foreach (v[i]) if (int'(v[i]) > hi) hi = int'(v[i]);
    r.max = word_t'(hi);
    r.idx = '0;
    for (int i = v.size() - 1; i >= 0; i--) if (int'(v[i]) == hi) r.idx = LOGM'(i);
    return r;
  endfunction

  word_t tx_q[$];
  word_t vec_q[$];
  res_t  exp_q[$];
  int    starts[$];

  int  rdy_mode = 1;
  bit  gap_en   = 1'b0;
  bit  acc_flag = 1'b0;
  int  cyc = 0;
  int  acc_count = 0;
  int  res_count = 0;
  int  mv_cycles = 0;

  always @(posedge clk) cyc++;

  // Upstream/downstream driver: holds a word until it is taken, optional random idle gaps.
  initial begin
    bus.s_valid = 1'b0;
    bus.data_in = '0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (acc_flag && tx_q.size() > 0) tx_q.delete(0);
      if (!(bus.s_valid && !acc_flag && tx_q.size() > 0))
        bus.s_valid = (tx_q.size() > 0) && !(gap_en && $urandom_range(3) == 0);
      bus.data_in = (tx_q.size() > 0) ? tx_q[0] : '0;
      case (rdy_mode)
        0:       bus.m_ready = 1'b0;
        1:       bus.m_ready = 1'b1;
        default: bus.m_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: samples handshakes mid-cycle, feeds the model and pops the scoreboard.
  bit              hold_v = 1'b0;
  logic [LOGM-1:0] hold_idx;
  word_t           hold_max;
  res_t            mon_e;

  always @(negedge clk) begin
    if (reset) begin
      vec_q.delete();
      exp_q.delete();
      hold_v   = 1'b0;
      acc_flag = 1'b0;
    end else begin
      if (bus.m_valid) mv_cycles++;
      if (hold_v) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_idx", bus.out_idx, hold_idx);
        check("hold_max", bus.out_max, hold_max);
      end
      hold_v   = bus.m_valid && !bus.m_ready;
      hold_idx = bus.out_idx;
      hold_max = bus.out_max;
      if (bus.m_valid && bus.m_ready) begin
        check("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("res_idx", bus.out_idx, mon_e.idx);
          check("res_max", bus.out_max, mon_e.max);
          res_count++;
        end
      end
      acc_flag = bus.s_valid && bus.s_ready;
      if (acc_flag) begin
        if (vec_q.size() == 0) starts.push_back(cyc);
        vec_q.push_back(bus.data_in);
        acc_count++;
        if (vec_q.size() == M) begin
          exp_q.push_back(ref_argmax(vec_q));
          vec_q.delete();
        end
      end
    end
  end

  task automatic push_vec(input int a, input int b, input int c, input int d);
    tx_q.push_back(word_t'(a));
    tx_q.push_back(word_t'(b));
    tx_q.push_back(word_t'(c));
    tx_q.push_back(word_t'(d));
  endtask

  task automatic push_rand_vec(input bit narrow);
    for (int i = 0; i < M; i++) begin
      if (narrow) tx_q.push_back(word_t'(int'($urandom_range(6)) - 3));
      else        tx_q.push_back(word_t'($urandom()));
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((tx_q.size() != 0 || vec_q.size() != 0 || exp_q.size() != 0 || bus.m_valid) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_done"}, n < budget, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, m0, a0, s0, n, exp_acc, exp_span;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_max", bus.out_max, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;
    check("s_ready_after_rst", bus.s_ready, 1);

    // Basic: one-cycle result pulse with m_ready held high
    r0 = res_count; m0 = mv_cycles;
    push_vec(5, -3, 12, 7);
    wait_idle("basic", 50);
    check("basic_results", res_count - r0, 1);
    check("basic_valid_cycles", mv_cycles - m0, 1);

    // Ties keep lowest index; all-negative needs a signed compare
    push_vec(7, 7, -1, 7);
    push_vec(-9, -108, -2, -30);
    wait_idle("ties_neg", 100);

    // Backpressure: result must hold while the next vector is offered
    rdy_mode = 0;
    a0 = acc_count;
    push_vec(1, 9, 3, 2);
    push_vec(4, 4, 4, 8);
    n = 0;
    while (!bus.m_valid && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("bp_seen", bus.m_valid, 1);
    repeat (10) begin
      check("bp_valid", bus.m_valid, 1);
      check("bp_idx", bus.out_idx, 1);
      check("bp_max", bus.out_max, 9);
      @(negedge clk); #1;
    end
`ifdef ARGMAX_SKID_EN
    exp_acc = 3;
`else
    exp_acc = 0;
`endif
    check("bp_accepted", acc_count - a0 - M, exp_acc);
    check("bp_s_ready", bus.s_ready, 0);
    rdy_mode = 1;
    wait_idle("bp_release", 100);

    // Reset mid-vector discards the partial vector
    push_vec(50, 60, 0, 0);
    tx_q.delete(3);
    tx_q.delete(2);
    n = 0;
    while (vec_q.size() < 2 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("mid_partial", vec_q.size(), 2);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); #1;
    check("mid_rst_s_ready", bus.s_ready, 0);
    check("mid_rst_m_valid", bus.m_valid, 0);
    @(posedge clk); #1 reset = 1'b0;
    r0 = res_count;
    push_vec(1, 2, 3, 4);
    wait_idle("mid_reset", 50);
    check("mid_results", res_count - r0, 1);

    // Throughput: 9 vectors back-to-back, measure 8 vector periods
    s0 = starts.size();
    r0 = res_count;
    for (int v = 0; v < 9; v++) push_rand_vec(v[0]);
    wait_idle("tput", 200);
    check("tput_results", res_count - r0, 9);
    check("tput_vectors", starts.size() - s0, 9);
`ifdef ARGMAX_SKID_EN
    exp_span = 8 * M;
`else
    exp_span = 8 * (M + 1);
`endif
    if (starts.size() - s0 >= 9) check("tput_cycles", starts[s0 + 8] - starts[s0], exp_span);

    // Random: idle gaps, random m_ready, mix of wide and tie-prone values
    gap_en = 1'b1;
    rdy_mode = 2;
    r0 = res_count;
    for (int v = 0; v < 40; v++) push_rand_vec($urandom_range(1) == 1);
    wait_idle("random", 3000);
    check("random_results", res_count - r0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
